// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Merges ALU results (buffered in a small
//               FIFO) and load results (priority) onto the register-file
//               write port, and tracks in-flight destination registers.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_dest,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    input  logic [ADDR_WIDTH-1:0]         mem_dest,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          write_enable,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [(2**ADDR_WIDTH)-1:0]    pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    logic                  r_active;
    logic [c_LVL_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_fifo_dest [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];

    logic                  r_hold_valid;
    logic [ADDR_WIDTH-1:0] r_hold_dest;
    logic [DATA_WIDTH-1:0] r_hold_data;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_valid;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [c_PTR_W-1:0]    w_offset;
    logic [c_REGS-1:0]     w_mask;

    // r_active keeps alu_ready low until the first edge after reset release
    assign alu_ready = r_active && (r_count != c_FULL);
    assign w_push    = alu_valid && alu_ready;
    assign w_pop     = !r_hold_valid && (r_count != '0);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        if (r_hold_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_hold_dest;
            w_sel_data  = r_hold_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_fifo_dest[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        w_mask   = '0;
        w_offset = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_offset = c_PTR_W'(i) - r_rd_ptr;
            if ({1'b0, w_offset} < r_count) begin
                w_mask[r_fifo_dest[i]] = 1'b1;
            end
        end
        if (r_hold_valid) begin
            w_mask[r_hold_dest] = 1'b1;
        end
        if (r_we) begin
            w_mask[r_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dest[r_wr_ptr] <= alu_dest;
            r_fifo_data[r_wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active     <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_hold_valid <= 1'b0;
            r_hold_dest  <= '0;
            r_hold_data  <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
            r_hold_valid <= mem_valid;
            if (mem_valid) begin
                r_hold_dest <= mem_dest;
                r_hold_data <= mem_data;
            end
            r_we <= w_sel_valid;
            if (w_sel_valid) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_addr;
    assign write_data   = r_data;
    assign pending_mask = w_mask;
    assign fifo_level   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage with a
//               behavioural register file fed by the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [2:0]  mem_dest;
    logic [15:0] mem_data;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic [7:0]  pending_mask;
    logic [2:0]  fifo_level;

    int          n_chk;
    int          n_err;
    int          idx;
    logic [15:0] regfile [8];
    logic [18:0] wlog [$];

    writeback_stage #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_dest     (alu_dest),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_dest     (mem_dest),
        .mem_data     (mem_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending_mask (pending_mask),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) begin
            regfile[write_addr] <= write_data;
            wlog.push_back({write_addr, write_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive a load (optional) and an ALU offer, advance idx on acceptance
    task automatic step(input bit do_load, input bit do_alu, input logic [15:0] base);
        logic acc;
        mem_valid = do_load;
        mem_dest  = 3'd0;
        mem_data  = 16'hB000 + 16'(idx);
        alu_valid = do_alu;
        alu_dest  = 3'(idx % 6 + 1);
        alu_data  = base + 16'(idx);
        acc       = do_alu && alu_ready;
        tick();
        if (acc) idx++;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) tick();
    endtask

    // Compare the ALU (non-zero address) writes logged since start against base+0..n-1
    task automatic check_alu_order(input string tag, input int start, input int n,
                                   input logic [15:0] base);
        int k;
        k = 0;
        for (int i = start; i < wlog.size(); i++) begin
            if (wlog[i][18:16] != 3'd0) begin
                check_value(tag, {16'd0, wlog[i][15:0]}, {16'd0, base + 16'(k)});
                k++;
            end
        end
        check_value({tag, "_count"}, k, n);
    endtask

    initial begin
        int mark;
        n_chk = 0;
        n_err = 0;
        idx   = 0;
        for (int i = 0; i < 8; i++) regfile[i] = 16'h0;
        reset     = 1'b0;
        alu_valid = 1'b0;
        alu_dest  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_dest  = '0;
        mem_data  = '0;

        // Reset state
        #3;
        check_value("rst_we",    write_enable, 0);
        check_value("rst_addr",  write_addr,   0);
        check_value("rst_data",  write_data,   0);
        check_value("rst_mask",  pending_mask, 0);
        check_value("rst_level", fifo_level,   0);
        check_value("rst_ready", alu_ready,    0);
        tick();
        tick();
        reset = 1'b1;
        check_value("ready_before_edge", alu_ready, 0);
        tick();
        check_value("ready_after_release", alu_ready, 1);

        // Single ALU write r3=A5A5
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hA5A5;
        tick();
        alu_valid = 1'b0;
        check_value("t1_mask_push", pending_mask, 8'h08);
        check_value("t1_level",     fifo_level,   1);
        check_value("t1_we_early",  write_enable, 0);
        tick();
        check_value("t1_we",   write_enable, 1);
        check_value("t1_addr", write_addr,   3);
        check_value("t1_data", write_data,   16'hA5A5);
        check_value("t1_mask_out", pending_mask, 8'h08);
        tick();
        check_value("t1_we_once", write_enable, 0);
        check_value("t1_mask_clr", pending_mask, 8'h00);
        check_value("t1_rf3", regfile[3], 16'hA5A5);

        // ALU r5 and load r6 in the same cycle
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h5A5A;
        mem_valid = 1'b1; mem_dest = 3'd6; mem_data = 16'h1234;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check_value("t2_mask_cap", pending_mask, 8'h60);
        check_value("t2_we0", write_enable, 0);
        tick();
        check_value("t2_addr_load", write_addr, 6);
        check_value("t2_data_load", write_data, 16'h1234);
        check_value("t2_mask_1", pending_mask, 8'h60);
        tick();
        check_value("t2_we_alu",   write_enable, 1);
        check_value("t2_addr_alu", write_addr, 5);
        check_value("t2_data_alu", write_data, 16'h5A5A);
        check_value("t2_mask_2", pending_mask, 8'h20);
        tick();
        check_value("t2_mask_3", pending_mask, 8'h00);
        check_value("t2_rf6", regfile[6], 16'h1234);
        check_value("t2_rf5", regfile[5], 16'h5A5A);

        // Six ALU results while loads arrive every cycle
        mark = wlog.size();
        idx  = 0;
        for (int c = 0; c < 6; c++) step(1'b1, idx < 6, 16'h1000);
        check_value("t3_level_full", fifo_level, 4);
        check_value("t3_ready_full", alu_ready, 0);
        check_value("t3_accepted", idx, 4);
        step(1'b0, 1'b1, 16'h1000);
        check_value("t3_ready_hold_drain", alu_ready, 0);
        check_value("t3_level_hold_drain", fifo_level, 4);
        step(1'b0, 1'b1, 16'h1000);
        check_value("t3_level_first_pop", fifo_level, 3);
        check_value("t3_ready_back", alu_ready, 1);
        for (int c = 0; c < 8 && idx < 6; c++) step(1'b0, 1'b1, 16'h1000);
        check_value("t3_all_pushed", idx, 6);
        drain();
        check_alu_order("t3_order", mark, 6, 16'h1000);

        // Full FIFO with pop in same cycle, then pointer wrap
        mark = wlog.size();
        idx  = 0;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 16'h2000);
        check_value("t4_level_full", fifo_level, 4);
        step(1'b0, 1'b1, 16'h2000);
        step(1'b0, 1'b1, 16'h2000);
        check_value("t4_no_push_on_pop", fifo_level, 3);
        check_value("t4_idx_after_pop", idx, 4);
        step(1'b0, 1'b1, 16'h2000);
        check_value("t4_push_accepted", idx, 5);
        check_value("t4_level_pushpop", fifo_level, 3);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 16'h2000);
        check_value("t4_wrap_level", fifo_level, 3);
        check_value("t4_wrap_idx", idx, 13);
        drain();
        check_alu_order("t4_order", mark, 13, 16'h2000);

        // Same register written twice
        mark = wlog.size();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick();
        alu_data = 16'h5678;
        tick();
        alu_valid = 1'b0;
        drain();
        check_value("t5_writes", wlog.size() - mark, 2);
        check_value("t5_first",  {13'd0, wlog[mark]},     {13'd0, 3'd3, 16'h1234});
        check_value("t5_second", {13'd0, wlog[mark + 1]}, {13'd0, 3'd3, 16'h5678});
        check_value("t5_rf3", regfile[3], 16'h5678);

        // Asynchronous reset with work in flight
        idx = 0;
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 16'h3000);
        check_value("t6_level_pre", fifo_level, 3);
        check_value("t6_we_pre", write_enable, 1);
        #2;
        reset = 1'b0;
        #1;
        check_value("t6_we_async",    write_enable, 0);
        check_value("t6_addr_async",  write_addr,   0);
        check_value("t6_data_async",  write_data,   0);
        check_value("t6_mask_async",  pending_mask, 0);
        check_value("t6_level_async", fifo_level,   0);
        check_value("t6_ready_async", alu_ready,    0);
        mark = wlog.size();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check_value("t6_no_write", wlog.size() - mark, 0);
        check_value("t6_level_post", fifo_level, 0);
        check_value("t6_mask_post", pending_mask, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
